// File: rtl/seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_disp_ctrl
// Purpose  : Bus register front end for the 8-digit 7-segment scanner, with a
//            sequential double-dabble binary-to-BCD path for decimal mode.
// Revision : 1.0
// ============================================================================
module seg_disp_ctrl #(
   parameter logic [7:0] RESET_EN   = 8'h00,
   parameter logic [3:0] OVF_NIBBLE = 4'hE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_bus_req,
   input  logic        i_bus_we,
   input  logic [1:0]  i_bus_addr,
   input  logic [31:0] i_bus_wdata,
   output logic        o_bus_ack,
   output logic [31:0] o_bus_rdata,
   output logic [31:0] o_disp_digits,
   output logic [7:0]  o_disp_en,
   output logic        o_disp_update
);

   localparam logic [1:0]  c_ADDR_VALUE  = 2'd0;
   localparam logic [1:0]  c_ADDR_CTRL   = 2'd1;
   localparam logic [1:0]  c_ADDR_ENABLE = 2'd2;
   localparam logic [1:0]  c_ADDR_STATUS = 2'd3;
   localparam logic [31:0] c_OVF_LIMIT   = 32'd100_000_000;
   localparam logic [4:0]  c_LAST_SHIFT  = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_value;
   logic        r_dec_mode;
   logic [7:0]  r_enable;
   logic        r_ovf;
   logic [31:0] r_shift;
   logic [31:0] r_bcd;
   logic [4:0]  r_cnt;
   logic        r_ack;
   logic [31:0] r_rdata;
   logic [31:0] r_digits;
   logic        r_update;

   logic        w_busy;
   logic        w_is_vc;
   logic        w_stall;
   logic        w_accept;
   logic        w_wr_vc;
   logic        w_wr_en;
   logic [31:0] w_new_value;
   logic        w_new_dec;
   logic        w_start_conv;
   logic        w_hex_commit;
   logic [31:0] w_rd_mux;
   logic [31:0] w_bcd_adj;

   assign w_busy       = (r_state != ST_IDLE);
   assign w_is_vc      = (i_bus_addr == c_ADDR_VALUE) || (i_bus_addr == c_ADDR_CTRL);
   // Only writes that would restart the converter wait for it to finish.
   assign w_stall      = i_bus_we & w_is_vc & w_busy;
   assign w_accept     = i_bus_req & ~r_ack & ~w_stall;
   assign w_wr_vc      = w_accept & i_bus_we & w_is_vc;
   assign w_wr_en      = w_accept & i_bus_we & (i_bus_addr == c_ADDR_ENABLE);
   assign w_new_value  = (i_bus_addr == c_ADDR_VALUE) ? i_bus_wdata : r_value;
   assign w_new_dec    = (i_bus_addr == c_ADDR_CTRL) ? i_bus_wdata[0] : r_dec_mode;
   assign w_start_conv = w_wr_vc & w_new_dec;
   assign w_hex_commit = w_wr_vc & ~w_new_dec;

   always_comb begin
      w_rd_mux = '0;
      case (i_bus_addr)
         c_ADDR_VALUE:  w_rd_mux = r_value;
         c_ADDR_CTRL:   w_rd_mux = {31'd0, r_dec_mode};
         c_ADDR_ENABLE: w_rd_mux = {24'd0, r_enable};
         c_ADDR_STATUS: w_rd_mux = {30'd0, r_ovf, w_busy};
         default:       w_rd_mux = '0;
      endcase
   end

   for (genvar k = 0; k < 8; k++) begin : g_adj
      assign w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ?
                                   (r_bcd[4*k +: 4] + 4'd3) : r_bcd[4*k +: 4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start_conv) w_state_nxt = ST_CONV;
         ST_CONV: if (r_cnt == c_LAST_SHIFT) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value    <= '0;
         r_dec_mode <= 1'b0;
         r_enable   <= RESET_EN;
         r_ovf      <= 1'b0;
         r_shift    <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_ack      <= 1'b0;
         r_rdata    <= '0;
         r_digits   <= '0;
         r_update   <= 1'b0;
      end else begin
         r_ack    <= w_accept;
         r_rdata  <= (w_accept && !i_bus_we) ? w_rd_mux : 32'd0;
         r_update <= w_wr_en | w_hex_commit | (r_state == ST_DONE);

         if (w_wr_vc) begin
            r_value    <= w_new_value;
            r_dec_mode <= w_new_dec;
         end
         if (w_wr_en) begin
            r_enable <= i_bus_wdata[7:0];
         end
         if (w_hex_commit) begin
            r_digits <= w_new_value;
            r_ovf    <= 1'b0;
         end

         if (w_start_conv) begin
            r_shift <= w_new_value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= (w_new_value >= c_OVF_LIMIT);
         end else if (r_state == ST_CONV) begin
            // Digits pushed past the eighth BCD nibble fall off; ovf covers them.
            {r_bcd, r_shift} <= {w_bcd_adj[30:0], r_shift, 1'b0};
            r_cnt            <= r_cnt + 5'd1;
         end

         if (r_state == ST_DONE) begin
            r_digits <= r_ovf ? {8{OVF_NIBBLE}} : r_bcd;
         end
      end
   end

   assign o_bus_ack     = r_ack;
   assign o_bus_rdata   = r_rdata;
   assign o_disp_digits = r_digits;
   assign o_disp_en     = r_enable;
   assign o_disp_update = r_update;

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_disp_ctrl
// Purpose  : Randomized self-checking bench for seg_disp_ctrl against a
//            decimal-arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_seg_disp_ctrl;

   localparam logic [7:0] c_RST_EN = 8'h3C;
   localparam logic [3:0] c_OVF    = 4'hE;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_bus_req;
   logic        i_bus_we;
   logic [1:0]  i_bus_addr;
   logic [31:0] i_bus_wdata;
   logic        o_bus_ack;
   logic [31:0] o_bus_rdata;
   logic [31:0] o_disp_digits;
   logic [7:0]  o_disp_en;
   logic        o_disp_update;

   seg_disp_ctrl #(.RESET_EN(c_RST_EN), .OVF_NIBBLE(c_OVF)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_bus_req     (i_bus_req),
      .i_bus_we      (i_bus_we),
      .i_bus_addr    (i_bus_addr),
      .i_bus_wdata   (i_bus_wdata),
      .o_bus_ack     (o_bus_ack),
      .o_bus_rdata   (o_bus_rdata),
      .o_disp_digits (o_disp_digits),
      .o_disp_en     (o_disp_en),
      .o_disp_update (o_disp_update)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          upd_cnt = 0;
   int          last_upd_cyc = 0;
   logic [31:0] last_digits = '0;

   logic [31:0] m_value;
   logic        m_dec;
   logic [7:0]  m_en;
   logic        m_ovf;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (o_disp_update) begin
         upd_cnt      = upd_cnt + 1;
         last_upd_cyc = cyc;
         last_digits  = o_disp_digits;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_disp(input logic [31:0] v, input logic dec);
      logic [31:0] r;
      int unsigned x;
      if (!dec) return v;
      if (v >= 32'd100_000_000) return {8{c_OVF}};
      r = '0;
      x = v;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int waits, output int acc);
      bit seen;
      @(negedge clk);
      i_bus_req   = 1'b1;
      i_bus_we    = we;
      i_bus_addr  = addr;
      i_bus_wdata = wdata;
      waits = 0;
      seen  = 0;
      rdata = '0;
      acc   = 0;
      while (!seen && waits <= 200) begin
         @(posedge clk);
         #1;
         if (o_bus_ack) seen = 1;
         else waits++;
      end
      if (!seen) check("ack_timeout", 32'd0, 32'd1);
      rdata     = o_bus_rdata;
      acc       = cyc;
      i_bus_req = 1'b0;
      @(posedge clk);
      #1;
      check("ack_one_cycle", {31'd0, o_bus_ack}, 32'd0);
      check("rdata_idle", o_bus_rdata, 32'd0);
   endtask

   task automatic read_check(input logic [1:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      int w, a;
      bus_xfer(1'b0, addr, 32'd0, rd, w, a);
      check($sformatf("rd_addr%0d", addr), rd, exp);
      check("rd_no_wait", w, 32'd0);
   endtask

   task automatic wait_dec(input int acc, input logic [31:0] exp, input int u);
      int n = 0;
      while (upd_cnt == u && n < 80) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("dec_latency", last_upd_cyc - acc, 32'd33);
      check("dec_digits", last_digits, exp);
      repeat (2) @(posedge clk);
      #1;
      check("dec_one_pulse", upd_cnt - u, 32'd1);
      check("dec_hold", o_disp_digits, exp);
   endtask

   task automatic write_and_check(input logic [1:0] addr, input logic [31:0] data);
      logic [31:0] rd;
      int w, a, u;
      u = upd_cnt;
      bus_xfer(1'b1, addr, data, rd, w, a);
      check("wr_no_wait", w, 32'd0);
      case (addr)
         2'd0: m_value = data;
         2'd1: m_dec = data[0];
         2'd2: m_en = data[7:0];
         default: ;
      endcase
      if (addr == 2'd2) begin
         check("en_out", o_disp_en, m_en);
         check("en_pulse_cyc", last_upd_cyc, a);
         check("en_one_pulse", upd_cnt - u, 32'd1);
      end else if (addr != 2'd3) begin
         m_ovf = m_dec && (m_value >= 32'd100_000_000);
         if (!m_dec) begin
            check("hex_digits", o_disp_digits, m_value);
            check("hex_pulse_cyc", last_upd_cyc, a);
            check("hex_one_pulse", upd_cnt - u, 32'd1);
         end else begin
            wait_dec(a, ref_disp(m_value, 1'b1), u);
         end
      end
   endtask

   initial begin
      logic [31:0] rd, v, r;
      int w, a1, a2, u;
      logic mode;

      rst_n = 1'b0;
      i_bus_req = 1'b0;
      i_bus_we = 1'b0;
      i_bus_addr = 2'd0;
      i_bus_wdata = '0;
      m_value = '0; m_dec = 1'b0; m_en = c_RST_EN; m_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_digits", o_disp_digits, 32'd0);
      check("rst_en", {24'd0, o_disp_en}, {24'd0, c_RST_EN});
      check("rst_ack", {31'd0, o_bus_ack}, 32'd0);
      check("rst_rdata", o_bus_rdata, 32'd0);
      check("rst_update", {31'd0, o_disp_update}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      read_check(2'd3, 32'd0);
      write_and_check(2'd1, 32'd0);
      write_and_check(2'd0, 32'hDEADBEEF);
      write_and_check(2'd1, 32'd1);
      write_and_check(2'd0, 32'd12345678);
      read_check(2'd3, 32'd0);
      write_and_check(2'd0, 32'd99999999);

      // overflow path with STATUS observed mid-conversion
      u = upd_cnt;
      bus_xfer(1'b1, 2'd0, 32'd100_000_000, rd, w, a1);
      m_value = 32'd100_000_000; m_ovf = 1'b1;
      read_check(2'd3, 32'h3);
      wait_dec(a1, {8{c_OVF}}, u);
      read_check(2'd3, 32'h2);

      // stalled write behind a conversion, ENABLE write passes through
      bus_xfer(1'b1, 2'd0, 32'd12345678, rd, w, a1);
      m_ovf = 1'b0;
      bus_xfer(1'b1, 2'd2, 32'h0000_00F0, rd, w, a2);
      m_en = 8'hF0;
      check("en_mid_no_wait", w, 32'd0);
      check("en_mid_out", {24'd0, o_disp_en}, 32'hF0);
      check("en_mid_pulse", last_upd_cyc, a2);
      u = upd_cnt;
      bus_xfer(1'b1, 2'd0, 32'd99, rd, w, a2);
      m_value = 32'd99;
      check("stall_accept", a2 - a1, 32'd34);
      check("first_commit_cyc", last_upd_cyc - a1, 32'd33);
      check("first_commit_val", last_digits, 32'h12345678);
      check("first_commit_pulses", upd_cnt - u, 32'd1);
      wait_dec(a2, 32'h0000_0099, upd_cnt);

      for (int i = 0; i < 12; i++) begin
         mode = 1'($urandom_range(0, 1));
         r = $urandom;
         write_and_check(2'd1, {r[31:1], mode});
         case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 999);
            1: v = $urandom_range(0, 99_999_999);
            2: v = $urandom;
            default: v = ($urandom_range(0, 1) != 0) ? 32'd99_999_999 : 32'd100_000_000;
         endcase
         write_and_check(2'd0, v);
         read_check(2'd1, {31'd0, m_dec});
         read_check(2'd0, m_value);
         read_check(2'd3, {30'd0, m_ovf, 1'b0});
         r = $urandom;
         write_and_check(2'd2, r);
         read_check(2'd2, {24'd0, m_en});
         write_and_check(2'd3, $urandom);
         read_check(2'd3, {30'd0, m_ovf, 1'b0});
      end

      // asynchronous reset during conversion
      write_and_check(2'd1, 32'd1);
      bus_xfer(1'b1, 2'd0, 32'd55555555, rd, w, a1);
      while (cyc < a1 + 10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_digits", o_disp_digits, 32'd0);
      check("arst_en", {24'd0, o_disp_en}, {24'd0, c_RST_EN});
      check("arst_ack", {31'd0, o_bus_ack}, 32'd0);
      check("arst_update", {31'd0, o_disp_update}, 32'd0);
      m_value = '0; m_dec = 1'b0; m_en = c_RST_EN; m_ovf = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      u = upd_cnt;
      repeat (40) @(posedge clk);
      #1;
      check("arst_no_commit", upd_cnt - u, 32'd0);
      check("arst_digits_hold", o_disp_digits, 32'd0);
      read_check(2'd3, 32'd0);
      read_check(2'd1, 32'd0);
      read_check(2'd0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Memory-mapped register front end for the eight-digit seven-segment display scanner.
- Sits between the CPU peripheral bus and the scanner; the scanner consumes its outputs.
- Holds a 32-bit display value, a per-digit enable mask and a mode bit.
- In hex mode it passes the value through as eight nibbles. In decimal mode it runs a sequential double-dabble conversion to eight BCD digits before committing.

Parameters:
RESET_EN, 8'h00, reset value of the ENABLE register and disp_en
OVF_NIBBLE, 4'hE, nibble replicated into all digits on decimal overflow

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bus_req  in  1  request; held by master until bus_ack seen
bus_we  in  1  1 = write, 0 = read
bus_addr  in  2  register index: 0 VALUE, 1 CTRL, 2 ENABLE, 3 STATUS
bus_wdata  in  32  write data
bus_ack  out  1  one-cycle acknowledge
bus_rdata  out  32  read data, valid while bus_ack=1
disp_digits  out  32  nibble [4k+3:4k] = digit k; digit 7 is leftmost
disp_en  out  8  digit enables; bit 7 = leftmost
disp_update  out  1  one-cycle pulse when disp_digits or disp_en change

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: VALUE=0, CTRL=0, ENABLE=RESET_EN, disp_digits=0, disp_en=RESET_EN, bus_ack=0, bus_rdata=0, disp_update=0, state=IDLE, ovf=0.
- Registers:
  - CTRL bit0 = dec_mode; other bits read 0.
  - ENABLE uses bits [7:0]; upper bits read 0.
  - STATUS bit0 = busy (state != IDLE), bit1 = ovf; read-only, writes are acked and ignored.
- Accept rule:
  - A request is accepted on a rising edge with bus_req=1, bus_ack=0, and not stalled.
  - A write to VALUE or CTRL is stalled while busy. Reads and ENABLE writes are never stalled.
  - bus_ack=1 during the cycle after the accept edge, for exactly one cycle. Master drops bus_req in that cycle.
- Reads: bus_rdata is the register value at the accept edge. bus_rdata returns 0 when bus_ack=0.
- ENABLE write: disp_en updates at the accept edge; disp_update pulses the following cycle.
- VALUE/CTRL write, resulting dec_mode=0: disp_digits <= new VALUE at the accept edge, ovf <= 0, disp_update pulses the following cycle.
- VALUE/CTRL write, resulting dec_mode=1:
  - At the accept edge: go to CONV, load shift register from VALUE, clear BCD accumulator, counter=0.
  - Sample ovf = (VALUE >= 100_000_000).
- State machine IDLE -> CONV -> DONE -> IDLE:
  - CONV: each edge, add 3 to every BCD nibble >= 5, then shift {bcd, shift} left 1; counter++. Exit to DONE after 32 shifts (edges 1..32 after accept).
  - DONE (edge 33): disp_digits <= ovf ? {8{OVF_NIBBLE}} : bcd; return to IDLE. disp_update pulses in the cycle after edge 33.
  - Total latency: 33 edges from accept to committed digits. busy=1 from accept edge through edge 33.
- Simultaneous events:
  - ENABLE write committing in the same edge as DONE: both apply, single disp_update pulse.
  - A stalled VALUE/CTRL write is accepted at the first edge with state=IDLE, i.e. the edge after DONE.
- Reset mid-conversion: CONV is aborted, all state returns to reset values, nothing is committed.
- Bits of the 32-bit double-dabble result above 8 BCD digits are discarded. That case is covered by ovf.

Test Plan:
- Reset, then read STATUS -> bus_ack one cycle later; rdata=0; disp_en=RESET_EN, disp_digits=0.
- Write CTRL=0, VALUE=0xDEADBEEF -> disp_digits=0xDEADBEEF one edge after accept; disp_update one pulse.
- Write CTRL=1, VALUE=12345678 -> STATUS.busy=1 for 33 edges; then disp_digits=0x12345678, ovf=0, single disp_update.
- Decimal mode, VALUE=100000000 -> disp_digits=0xEEEEEEEE, STATUS=0x3 before completion, 0x2 after.
- During conversion, write VALUE=99 -> bus_ack withheld until the edge after DONE. First commit completes, then second conversion yields 0x00000099. An ENABLE=0xF0 write during conversion is acked immediately with disp_en=0xF0.
- Assert rst_n low at CONV edge 10 -> outputs return to reset values asynchronously; no disp_update afterward.
